// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared owner-state encoding and default bus widths for mem_arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {NONE, RSP_I, RSP_D} owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) single-memory arbiter with one-cycle response routing.
// Optional MEM_ARB_FAIRNESS_EN adds a fetch starvation counter that overrides data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_mask,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata
);
  logic   fetch_pri;
  logic   i_gnt, d_gnt;
  logic   wr_q;
  owner_t owner;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;
  assign fetch_pri = starve == CW'(STARVE_MAX);
  // Fetch is always granted once saturated, so incrementing only below the cap saturates it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else if (i_gnt) starve <= '0;
    else if (i_req_valid && !fetch_pri) starve <= starve + 1'b1;
`else
  assign fetch_pri = 1'b0;
`endif
  assign d_req_ready = d_req_valid && !(fetch_pri && i_req_valid);
  assign i_req_ready = i_req_valid && (!d_req_valid || fetch_pri);
  assign d_gnt       = d_req_ready;
  assign i_gnt       = i_req_ready;
  assign mem_en      = i_gnt || d_gnt;
  assign mem_we      = d_gnt && d_req_we;
  assign mem_addr    = d_gnt ? d_req_addr : i_req_addr;
  assign mem_wdata   = d_gnt ? d_req_wdata : '0;
  assign mem_mask    = d_gnt ? d_req_mask : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= NONE;
      wr_q  <= 1'b0;
    end else begin
      owner <= d_gnt ? RSP_D : i_gnt ? RSP_I : NONE;
      wr_q  <= d_gnt && d_req_we;
    end
  assign i_rsp_valid = owner == RSP_I;
  assign d_rsp_valid = owner == RSP_D;
  assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
  assign d_rsp_data  = (d_rsp_valid && !wr_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a byte-masked behavioural memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_data;
  logic [3:0]    d_req_mask, mem_mask;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [0:255];
  int vec = 0;
  int err = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_mask(d_req_mask),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_en) mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic idle();
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_mask = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #1;
    vec++; if (i_rsp_valid !== 1'b0) begin err++; $display("FAIL reset_i_rsp_valid got=%0h exp=0", i_rsp_valid); end
    vec++; if (d_rsp_valid !== 1'b0) begin err++; $display("FAIL reset_d_rsp_valid got=%0h exp=0", d_rsp_valid); end
    vec++; if (mem_en !== 1'b0) begin err++; $display("FAIL reset_mem_en got=%0h exp=0", mem_en); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    vec++; if (i_rsp_data !== 32'h0) begin err++; $display("FAIL reset_i_rsp_data got=%h exp=0", i_rsp_data); end
    vec++; if (d_rsp_data !== 32'h0) begin err++; $display("FAIL reset_d_rsp_data got=%h exp=0", d_rsp_data); end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h100;
    #1;
    vec++; if (i_req_ready !== 1'b1) begin err++; $display("FAIL fetch_ready got=%0h exp=1", i_req_ready); end
    vec++; if (d_req_ready !== 1'b0) begin err++; $display("FAIL fetch_d_ready got=%0h exp=0", d_req_ready); end
    vec++; if ({mem_en, mem_we, mem_mask} !== 6'b10_0000) begin err++; $display("FAIL fetch_mem_ctl got=%b exp=100000", {mem_en, mem_we, mem_mask}); end
    vec++; if (mem_addr !== 32'h100) begin err++; $display("FAIL fetch_mem_addr got=%h exp=00000100", mem_addr); end
    @(negedge clk);
    idle();
    #1;
    vec++; if (i_rsp_valid !== 1'b1) begin err++; $display("FAIL fetch_rsp_valid got=%0h exp=1", i_rsp_valid); end
    vec++; if (i_rsp_data !== 32'hDEADBEEF) begin err++; $display("FAIL fetch_rsp_data got=%h exp=deadbeef", i_rsp_data); end
    vec++; if (d_rsp_valid !== 1'b0) begin err++; $display("FAIL fetch_d_rsp_valid got=%0h exp=0", d_rsp_valid); end
    @(negedge clk); #1;
    vec++; if ({i_rsp_valid, i_rsp_data} !== 33'h0) begin err++; $display("FAIL fetch_rsp_idle got=%h exp=0", {i_rsp_valid, i_rsp_data}); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h0;
    d_req_valid = 1; d_req_addr = 32'h40; d_req_we = 0;
    #1;
    vec++; if ({d_req_ready, i_req_ready} !== 2'b10) begin err++; $display("FAIL prio_first_grant got=%b exp=10", {d_req_ready, i_req_ready}); end
    vec++; if (mem_addr !== 32'h40) begin err++; $display("FAIL prio_first_addr got=%h exp=00000040", mem_addr); end
    @(negedge clk);
    d_req_valid = 0;
    #1;
    vec++; if (i_req_ready !== 1'b1) begin err++; $display("FAIL prio_second_grant got=%0h exp=1", i_req_ready); end
    vec++; if (mem_addr !== 32'h0) begin err++; $display("FAIL prio_second_addr got=%h exp=0", mem_addr); end
    vec++; if ({d_rsp_valid, i_rsp_valid} !== 2'b10) begin err++; $display("FAIL prio_d_rsp_route got=%b exp=10", {d_rsp_valid, i_rsp_valid}); end
    vec++; if (d_rsp_data !== 32'h0BADF00D) begin err++; $display("FAIL prio_d_rsp_data got=%h exp=0badf00d", d_rsp_data); end
    @(negedge clk);
    idle();
    #1;
    vec++; if ({d_rsp_valid, i_rsp_valid} !== 2'b01) begin err++; $display("FAIL prio_i_rsp_route got=%b exp=01", {d_rsp_valid, i_rsp_valid}); end
    vec++; if (i_rsp_data !== 32'h11223344) begin err++; $display("FAIL prio_i_rsp_data got=%h exp=11223344", i_rsp_data); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h80; d_req_wdata = 32'h12345678; d_req_mask = 4'b0011;
    #1;
    vec++; if ({mem_en, mem_we, mem_mask} !== 6'b11_0011) begin err++; $display("FAIL wr_mem_ctl got=%b exp=110011", {mem_en, mem_we, mem_mask}); end
    vec++; if (mem_wdata !== 32'h12345678) begin err++; $display("FAIL wr_mem_wdata got=%h exp=12345678", mem_wdata); end
    @(negedge clk);
    d_req_we = 0; d_req_wdata = '0; d_req_mask = '0;
    #1;
    vec++; if ({d_req_ready, mem_we} !== 2'b10) begin err++; $display("FAIL rd_grant got=%b exp=10", {d_req_ready, mem_we}); end
    vec++; if (d_rsp_valid !== 1'b1) begin err++; $display("FAIL wr_ack_valid got=%0h exp=1", d_rsp_valid); end
    vec++; if (d_rsp_data !== 32'h0) begin err++; $display("FAIL wr_ack_data got=%h exp=0", d_rsp_data); end
    @(negedge clk);
    idle();
    #1;
    vec++; if (d_rsp_valid !== 1'b1) begin err++; $display("FAIL rd_rsp_valid got=%0h exp=1", d_rsp_valid); end
    vec++; if (d_rsp_data !== 32'hCAFE5678) begin err++; $display("FAIL rd_rsp_data got=%h exp=cafe5678", d_rsp_data); end
  endtask

  task automatic test_arbitration();
    logic exp_i;
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h0;
    d_req_valid = 1; d_req_addr = 32'h40; d_req_we = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef MEM_ARB_FAIRNESS_EN
      exp_i = (k % (SM + 1)) == SM;
`else
      exp_i = 1'b0;
`endif
      vec++; if ({i_req_ready, d_req_ready} !== {exp_i, ~exp_i}) begin err++; $display("FAIL arb_cycle%0d got=%b exp=%b", k, {i_req_ready, d_req_ready}, {exp_i, ~exp_i}); end
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h100;
    @(posedge clk);
    #1;
    rst_n = 0;
    idle();
    #1;
    vec++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin err++; $display("FAIL rst_drop_valid got=%b exp=00", {i_rsp_valid, d_rsp_valid}); end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      vec++; if ({i_rsp_valid, d_rsp_valid, mem_en, mem_we} !== 4'b0000) begin err++; $display("FAIL rst_idle_ctl%0d got=%b exp=0000", k, {i_rsp_valid, d_rsp_valid, mem_en, mem_we}); end
      vec++; if ({i_rsp_data, d_rsp_data} !== 64'h0) begin err++; $display("FAIL rst_idle_data%0d got=%h exp=0", k, {i_rsp_data, d_rsp_data}); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h40 >> 2]  = 32'h0BADF00D;
    mem[32'h0 >> 2]   = 32'h11223344;
    mem[32'h80 >> 2]  = 32'hCAFEBABE;
    test_reset();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_arbitration();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
